// File: rtl/aes_gcm_decrypt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_gcm_decrypt : AES-256-GCM decrypt/verify, one AES core and one GHASH    |
// | multiplier time-shared by a 13-state FSM. Option: GCM_DEC_PT_GATE_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module aes_encr (
  input  logic [255:0] key,
  input  logic [127:0] block_in,
  output logic [127:0] block_out
);
  logic [31:0]  w [0:59];
  logic [31:0]  temp;
  logic [127:0] st;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse as a^254 (= a^2 * a^4 * ... * a^128), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] inv;
    s   = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s   = gmul(s, s);
      inv = gmul(inv, s);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox(s[127-8*((i + 4*(i%4)) % 16) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  always_comb begin
    temp = '0;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0)      temp = sub_word({temp[23:0], temp[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
      else if (i % 8 == 4) temp = sub_word(temp);
      w[i] = w[i-8] ^ temp;
    end
    st = block_in ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 14; r++) begin
      st = sub_shift(st);
      if (r != 14) st = mix_cols(st);
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    block_out = st;
  end
endmodule

module ghash (
  input  logic [127:0] acc,
  input  logic [127:0] x,
  input  logic [127:0] h,
  output logic [127:0] y
);
  logic [127:0] a, z, v;

  // Bit-reflected GF(2^128) multiply, reduction polynomial 0xE1 << 120
  always_comb begin
    a = acc ^ x;
    z = '0;
    v = h;
    for (int i = 127; i >= 0; i--) begin
      if (a[i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    y = z;
  end
endmodule

module aes_gcm_decrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [223:0] aad,
  input  logic [127:0] ciphertext1,
  input  logic [127:0] ciphertext2,
  input  logic [127:0] ciphertext3,
  input  logic [127:0] tag_in,
  output logic [127:0] plaintext1,
  output logic [127:0] plaintext2,
  output logic [127:0] plaintext3,
  output logic         auth_ok,
  output logic         done,
  output logic         busy
);
  localparam logic [3:0] IDLE = 4'd0,  HKEY = 4'd1,  MASK = 4'd2,  KS1 = 4'd3,  KS2 = 4'd4;
  localparam logic [3:0] KS3  = 4'd5,  G1   = 4'd6,  G2   = 4'd7,  G3  = 4'd8,  G4  = 4'd9;
  localparam logic [3:0] G5   = 4'd10, G6   = 4'd11, CHECK = 4'd12;

  logic [3:0]   state;
  logic [255:0] lat_key;
  logic [95:0]  lat_nonce;
  logic [223:0] lat_aad;
  logic [127:0] lat_c1, lat_c2, lat_c3, lat_tag;
  logic [127:0] hkey, mask, acc, pt1, pt2, pt3;
  logic [127:0] aes_in, aes_out, gh_x, gh_y;
  logic         accept;

  aes_encr u_aes (.key(lat_key), .block_in(aes_in), .block_out(aes_out));
  ghash    u_gh  (.acc(acc), .x(gh_x), .h(hkey), .y(gh_y));

  // The done edge doubles as an accept slot so back-to-back operations lose no cycle
  assign accept = start && (state == IDLE || state == CHECK);

  always_comb begin
    aes_in = '0;
    case (state)
      MASK:    aes_in = {lat_nonce, 32'd1};
      KS1:     aes_in = {lat_nonce, 32'd2};
      KS2:     aes_in = {lat_nonce, 32'd3};
      KS3:     aes_in = {lat_nonce, 32'd4};
      default: aes_in = '0;
    endcase
    gh_x = {64'd224, 64'd384};
    case (state)
      G1:      gh_x = lat_aad[223:96];
      G2:      gh_x = {lat_aad[95:0], 32'h0};
      G3:      gh_x = lat_c1;
      G4:      gh_x = lat_c2;
      G5:      gh_x = lat_c3;
      default: gh_x = {64'd224, 64'd384};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lat_key <= '0; lat_nonce <= '0; lat_aad <= '0;
      lat_c1 <= '0; lat_c2 <= '0; lat_c3 <= '0; lat_tag <= '0;
      hkey <= '0; mask <= '0; acc <= '0;
      pt1 <= '0; pt2 <= '0; pt3 <= '0;
      auth_ok <= 1'b0; done <= 1'b0; busy <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        HKEY: begin
          hkey <= aes_out;
          pt1 <= '0; pt2 <= '0; pt3 <= '0;
          auth_ok <= 1'b0;
          state <= MASK;
        end
        MASK:   begin mask <= aes_out;          state <= KS1; end
        KS1:    begin pt1 <= lat_c1 ^ aes_out;  state <= KS2; end
        KS2:    begin pt2 <= lat_c2 ^ aes_out;  state <= KS3; end
        KS3:    begin pt3 <= lat_c3 ^ aes_out;  state <= G1;  end
        G1, G2, G3, G4, G5, G6: begin
          acc   <= gh_y;
          state <= state + 4'd1;
        end
        CHECK: begin
          auth_ok <= ((acc ^ mask) == lat_tag);
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        lat_key <= key; lat_nonce <= nonce; lat_aad <= aad;
        lat_c1 <= ciphertext1; lat_c2 <= ciphertext2; lat_c3 <= ciphertext3;
        lat_tag <= tag_in;
        acc   <= '0;
        busy  <= 1'b1;
        state <= HKEY;
        if (state == IDLE) begin
          pt1 <= '0; pt2 <= '0; pt3 <= '0;
          auth_ok <= 1'b0;
        end
      end
    end
  end

`ifdef GCM_DEC_PT_GATE_EN
  assign plaintext1 = auth_ok ? pt1 : '0;
  assign plaintext2 = auth_ok ? pt2 : '0;
  assign plaintext3 = auth_ok ? pt3 : '0;
`else
  assign plaintext1 = pt1;
  assign plaintext2 = pt2;
  assign plaintext3 = pt3;
`endif
endmodule

`default_nettype wire

// File: tb/tb_aes_gcm_decrypt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_gcm_decrypt : directed bench with an independent AES-GCM reference.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aes_gcm_decrypt;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [223:0] aad;
  logic [127:0] ciphertext1, ciphertext2, ciphertext3, tag_in;
  logic [127:0] plaintext1, plaintext2, plaintext3;
  logic         auth_ok, done, busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   sb [0:255];
  logic [127:0] c1, c2, c3, tg;
  logic [255:0] k2;
  logic [95:0]  n2;
  logic [127:0] p1, p2, p3;

  always #5 clk = ~clk;

  aes_gcm_decrypt dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce), .aad(aad),
    .ciphertext1(ciphertext1), .ciphertext2(ciphertext2), .ciphertext3(ciphertext3),
    .tag_in(tag_in), .plaintext1(plaintext1), .plaintext2(plaintext2),
    .plaintext3(plaintext3), .auth_ok(auth_ok), .done(done), .busy(busy)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, cst;
    cst = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm8(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb[a] = s;
    end
  endtask

  function automatic logic [127:0] m_aes(input logic [255:0] k, input logic [127:0] p);
    logic [7:0] rk [0:239];
    logic [7:0] s [0:15];
    logic [7:0] t [0:15];
    logic [7:0] t0, t1, t2, t3, tt, rc;
    logic [127:0] o;
    for (int i = 0; i < 32; i++) rk[i] = k[255-8*i -: 8];
    rc = 8'h01;
    for (int i = 32; i < 240; i += 4) begin
      t0 = rk[i-4]; t1 = rk[i-3]; t2 = rk[i-2]; t3 = rk[i-1];
      if (i % 32 == 0) begin
        tt = t0; t0 = sb[t1] ^ rc; t1 = sb[t2]; t2 = sb[t3]; t3 = sb[tt];
        rc = gm8(rc, 8'h02);
      end else if (i % 32 == 16) begin
        t0 = sb[t0]; t1 = sb[t1]; t2 = sb[t2]; t3 = sb[t3];
      end
      rk[i] = rk[i-32] ^ t0; rk[i+1] = rk[i-31] ^ t1;
      rk[i+2] = rk[i-30] ^ t2; rk[i+3] = rk[i-29] ^ t3;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk[i];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i + 4*(i%4)) % 16]];
      for (int c = 0; c < 4; c++) begin
        if (r < 14) begin
          s[4*c]   = gm8(t[4*c],8'h02) ^ gm8(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm8(t[4*c+1],8'h02) ^ gm8(t[4*c+2],8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm8(t[4*c+2],8'h02) ^ gm8(t[4*c+3],8'h03);
          s[4*c+3] = gm8(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm8(t[4*c+3],8'h02);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r+i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] m_gh(input logic [127:0] y, input logic [127:0] x, input logic [127:0] h);
    logic [127:0] a, z, v;
    a = y ^ x; z = '0; v = h;
    for (int i = 0; i < 128; i++) begin
      if (a[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  task automatic gcm_enc(input logic [255:0] k, input logic [95:0] n, input logic [223:0] a,
                         input logic [127:0] q1, input logic [127:0] q2, input logic [127:0] q3,
                         output logic [127:0] o1, output logic [127:0] o2,
                         output logic [127:0] o3, output logic [127:0] ot);
    logic [127:0] h, s;
    h  = m_aes(k, '0);
    o1 = q1 ^ m_aes(k, {n, 32'd2});
    o2 = q2 ^ m_aes(k, {n, 32'd3});
    o3 = q3 ^ m_aes(k, {n, 32'd4});
    s = m_gh('0, a[223:96], h);
    s = m_gh(s, {a[95:0], 32'h0}, h);
    s = m_gh(s, o1, h);
    s = m_gh(s, o2, h);
    s = m_gh(s, o3, h);
    s = m_gh(s, {64'd224, 64'd384}, h);
    ot = s ^ m_aes(k, {n, 32'd1});
  endtask

  function automatic logic [127:0] gate(input logic [127:0] p, input logic ok);
`ifdef GCM_DEC_PT_GATE_EN
    return ok ? p : '0;
`else
    return p;
`endif
  endfunction

  task automatic apply(input logic [255:0] k, input logic [95:0] n, input logic [223:0] a, input logic [127:0] t);
    key = k; nonce = n; aad = a; tag_in = t;
    ciphertext1 = c1; ciphertext2 = c2; ciphertext3 = c3;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [127:0] e1, input logic [127:0] e2,
                       input logic [127:0] e3, input logic eok, input bit scramble);
    int cyc, early_ok;
    pulse_start();
    if (scramble) begin
      key = ~key; nonce = ~nonce; aad = ~aad; tag_in = ~tag_in;
      ciphertext1 = ~ciphertext1; ciphertext2 = ~ciphertext2; ciphertext3 = ~ciphertext3;
    end
    check({name, "_busy_on"}, busy, 1);
    cyc = 0; early_ok = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (auth_ok !== 1'b0) early_ok++;
      @(posedge clk); #1; cyc++;
    end
    check({name, "_latency"}, cyc, 12);
    check({name, "_auth_low"}, early_ok, 0);
    check({name, "_pt1"}, plaintext1, gate(e1, eok));
    check({name, "_pt2"}, plaintext2, gate(e2, eok));
    check({name, "_pt3"}, plaintext3, gate(e3, eok));
    check({name, "_auth"}, auth_ok, eok);
    check({name, "_busy_off"}, busy, 0);
    @(posedge clk); #1;
    check({name, "_done_1cyc"}, done, 0);
    check({name, "_pt1_hold"}, plaintext1, gate(e1, eok));
  endtask

  initial begin
    int nd, d12, d24, ok12, ok24;
    logic [127:0] pt24;
    rst = 1'b0; start = 1'b0;
    key = '0; nonce = '0; aad = '0; tag_in = '0;
    ciphertext1 = '0; ciphertext2 = '0; ciphertext3 = '0;
    k2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    n2 = 96'hCAFEBABEFACEDBADDECAF888;
    p1 = {16{8'h11}}; p2 = {16{8'h22}}; p3 = {16{8'h33}};
    build_sbox();

    // Anchor the reference model on published AES-256-GCM vectors
    check("model_H", m_aes('0, '0), 128'hdc95c078a2408989ad48a21492842087);
    check("model_EY0", m_aes('0, {96'h0, 32'd1}), 128'h530f8afbc74536b9a963b4f1c4cb738b);
    check("model_C1", m_aes('0, {96'h0, 32'd2}), 128'hcea7403d4d606b6e074ec5d3baf39d18);
    check("model_tag", m_gh(m_gh('0, 128'hcea7403d4d606b6e074ec5d3baf39d18, 128'hdc95c078a2408989ad48a21492842087),
                            {64'd0, 64'd128}, 128'hdc95c078a2408989ad48a21492842087)
                       ^ 128'h530f8afbc74536b9a963b4f1c4cb738b, 128'hd0d1c8a799996bf0265b98b5d48ab919);

    repeat (3) @(posedge clk); #1;
    check("rst_pt1", plaintext1, 0);
    check("rst_pt3", plaintext3, 0);
    check("rst_auth", auth_ok, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); rst = 1'b1;

    gcm_enc('0, '0, '0, '0, '0, '0, c1, c2, c3, tg);
    apply('0, '0, '0, tg);
    do_op("zero", '0, '0, '0, 1'b1, 1'b0);

    gcm_enc(k2, n2, '0, p1, p2, p3, c1, c2, c3, tg);
    apply(k2, n2, '0, tg);
    do_op("k2", p1, p2, p3, 1'b1, 1'b1);
    apply(k2, n2, '0, tg ^ 128'h1);
    do_op("tagflip", p1, p2, p3, 1'b0, 1'b0);
    apply(k2, n2, 224'h1, tg);
    do_op("aadflip", p1, p2, p3, 1'b0, 1'b0);

    // Starts at k+3 and k+11 are ignored; the one on the done edge chains a new op
    apply(k2, n2, '0, tg);
    pulse_start();
    nd = 0; d12 = 0; d24 = 0; ok12 = 0; ok24 = 0; pt24 = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk); start = (c == 3 || c == 11 || c == 12);
      @(posedge clk); #1;
      if (done === 1'b1) begin
        nd++;
        if (c == 12) begin d12 = 1; ok12 = int'(auth_ok); end
        if (c == 24) begin d24 = 1; ok24 = int'(auth_ok); pt24 = plaintext2; end
      end
    end
    start = 1'b0;
    check("b2b_pulses", nd, 2);
    check("b2b_done12", d12, 1);
    check("b2b_done24", d24, 1);
    check("b2b_auth12", ok12, 1);
    check("b2b_auth24", ok24, 1);
    check("b2b_pt2", pt24, gate(p2, 1'b1));

    // Abort mid-operation with reset
    apply(k2, n2, '0, tg);
    pulse_start();
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("abort_pt1", plaintext1, 0);
    check("abort_auth", auth_ok, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    nd = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) nd++;
    end
    check("abort_no_done", nd, 0);
    @(negedge clk); rst = 1'b1;

    gcm_enc('0, '0, '0, '0, '0, '0, c1, c2, c3, tg);
    apply('0, '0, '0, tg);
    do_op("rerun", '0, '0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/aes_gcm_decrypt.md
AES_GCM_DECRYPT -- requirements
Module: aes_gcm_decrypt

Interface
REQ-001 The block SHALL have no parameters; the geometry is fixed at 224-bit AAD, three 128-bit blocks and a 256-bit key.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only while busy=0.
REQ-005 key  input  256  AES-256 key.
REQ-006 nonce  input  96  GCM IV.
REQ-007 aad  input  224  additional authenticated data, MSB-first.
REQ-008 ciphertext1/2/3  input  128 each  ciphertext blocks C1..C3.
REQ-009 tag_in  input  128  received authentication tag.
REQ-010 plaintext1/2/3  output  128 each  recovered plaintext, registered.
REQ-011 auth_ok  output  1  registered; 1 when the computed tag equals tag_in.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high from the start-accept edge until the done edge.

Function
REQ-014 The block SHALL instantiate exactly one aes_encr and one ghash, each used once per cycle under FSM control.
REQ-015 On start=1 with busy=0 at edge k, the block SHALL latch key, nonce, aad, ciphertext1-3 and tag_in, and SHALL clear plaintext1-3, auth_ok and the GHASH accumulator.
REQ-016 FSM states SHALL be IDLE, HKEY, MASK, KS1, KS2, KS3, G1-G6, CHECK; after start-accept, each state SHALL last one cycle in this order, and CHECK SHALL return to IDLE.
REQ-017 HKEY SHALL register H = AES_K(0^128).
REQ-018 MASK SHALL register E(K, {nonce, 32'd1}).
REQ-019 KSn (n=1..3) SHALL register plaintextn = Cn XOR E(K, {nonce, 32'd(n+1)}).
REQ-020 G1-G6 SHALL update acc = ghash(acc, X, H) with X in this order: aad[223:96], {aad[95:0], 32'h0}, C1, C2, C3, {64'd224, 64'd384}.
REQ-021 CHECK SHALL compute auth_ok = ((acc XOR mask) == tag_in) over all 128 bits.
REQ-022 The edge that leaves CHECK SHALL set done=1 and busy=0; this edge SHALL be edge k+12.
REQ-023 done SHALL be 1 for exactly one cycle.
REQ-024 auth_ok and plaintext1-3 SHALL hold their values until the next start is accepted.
REQ-025 start while busy=1 SHALL be ignored, with no effect on state, outputs or latched data.
REQ-026 A start sampled on the done edge (busy=0) SHALL be accepted and begin a new operation.
REQ-027 Input changes after the start-accept edge SHALL NOT affect the result.
REQ-028 auth_ok SHALL remain 0 throughout an operation until the CHECK-exit edge.

Reset
REQ-029 rst=0 SHALL asynchronously force the FSM to IDLE and clear plaintext1-3, auth_ok, done, busy, all latched inputs, H, mask and acc to 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst returns to 1 SHALL complete normally.

Configuration
REQ-031 With GCM_DEC_PT_GATE_EN defined, plaintext1-3 SHALL read 128'h0 whenever auth_ok=0, including during an operation, so unauthenticated plaintext is never exposed.
REQ-032 Without GCM_DEC_PT_GATE_EN, plaintext1-3 SHALL expose the registered XOR result regardless of auth_ok.

Verification
REQ-033 Loopback: for key=0, nonce=0, aad=0, P1-P3=0, drive aes_gcm_top ciphertext/tag into the block -> plaintext1-3=0, auth_ok=1, done exactly 12 cycles after the start edge.
REQ-034 Same as REQ-033 with key=256'h000102..1F, nonce=96'hCAFEBABEFACEDBADDECAF888, P1-P3=128'h1111..., 128'h2222..., 128'h3333... -> plaintexts match, auth_ok=1.
REQ-035 REQ-034 stimulus with tag_in bit 0 flipped, then separately with aad bit 0 flipped -> auth_ok=0 in both runs; plaintexts correct without GCM_DEC_PT_GATE_EN, all-zero with it.
REQ-036 Pulse start again at cycles k+3 and k+11 -> both ignored, single done at k+12; start held high on the done edge -> second operation completes at k+24.
REQ-037 Assert rst=0 at cycle k+5 -> all outputs 0 immediately, no done; REQ-033 then reruns correctly.
